// File: rtl/powerup_manager_if.sv
// Bundle of the game-logic signals between the powerup manager and its
// surroundings. The slave side is the manager itself.
interface powerup_manager_if;
    logic       OneSecPulse;
    logic       startOfFrame;
    logic       score_reset;
    logic       player_powerup_collision;
    logic [1:0] powerup_type;
    logic [3:0] bombs_left;
    logic       inc_bomb;
    logic [2:0] blast_num;
    logic       boost_active;
    logic [3:0] boost_secs_left;
    logic       powerup_taken;
    logic [1:0] powerup_kind;

    modport master (
        output OneSecPulse, startOfFrame, score_reset,
               player_powerup_collision, powerup_type, bombs_left,
        input  inc_bomb, blast_num, boost_active, boost_secs_left,
               powerup_taken, powerup_kind
    );

    modport slave (
        input  OneSecPulse, startOfFrame, score_reset,
               player_powerup_collision, powerup_type, bombs_left,
        output inc_bomb, blast_num, boost_active, boost_secs_left,
               powerup_taken, powerup_kind
    );
endinterface

// File: rtl/powerup_manager.sv
// Powerup manager: filters sprite collisions down to one pickup per frame,
// queues extra-bomb requests toward the bomb system, tracks the permanent
// blast range and runs a timed range boost.
//
// Boost FSM
//   state      | meaning
//   ST_IDLE    | no boost running, timer is 0
//   ST_BOOSTED | boost running, timer counts down on OneSecPulse
module powerup_manager #(
    parameter int BOOST_SECS     = 10,
    parameter int BASE_RANGE     = 1,
    parameter int MAX_BASE_RANGE = 4,
    parameter int MAX_PENDING    = 3
) (
    input  logic               clk,
    input  logic               resetN,
    powerup_manager_if.slave   pif
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [1:0] T_BOMB  = 2'b00;
    localparam logic [1:0] T_RANGE = 2'b01;
    localparam logic [1:0] T_BOOST = 2'b10;
    localparam logic [1:0] T_NONE  = 2'b11;

    typedef enum logic {ST_IDLE, ST_BOOSTED} boost_state_e;

    boost_state_e state_q, state_d;
    logic [3:0]    timer_q, timer_d;
    logic          latch_q, latch_d;
    logic          taken_q, taken_d;
    logic [1:0]    kind_q, kind_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          inc_q, inc_d;
    logic          inc_hist_q, inc_hist_d;
    logic [2:0]    base_q, base_d;
    logic [2:0]    blast_q, blast_d;

    logic       accept;
    logic       bomb_pick, range_pick, boost_pick;
    logic       fire;
    logic [3:0] blast_sum;

    // Pickup filter: first valid collision of a frame wins; a startOfFrame in
    // the same cycle reopens the frame before the collision is judged.
    always_comb begin
        accept     = pif.player_powerup_collision && (pif.powerup_type != T_NONE)
                     && (!latch_q || pif.startOfFrame) && !pif.score_reset;
        bomb_pick  = accept && (pif.powerup_type == T_BOMB);
        range_pick = accept && (pif.powerup_type == T_RANGE);
        boost_pick = accept && (pif.powerup_type == T_BOOST);

        latch_d = latch_q;
        if (pif.score_reset)       latch_d = 1'b0;
        else if (accept)           latch_d = 1'b1;
        else if (pif.startOfFrame) latch_d = 1'b0;

        taken_d = accept;
        kind_d  = kind_q;
        if (pif.score_reset) kind_d = 2'b00;
        else if (accept)     kind_d = pif.powerup_type;
    end

    // Bomb request queue; the two-cycle gap lets bombs_left catch up after
    // each request before the next one is considered.
    always_comb begin
        fire = (pending_q != '0) && (pif.bombs_left < 4'd3) && !inc_q && !inc_hist_q;

        pending_d = pending_q;
        if (bomb_pick && !fire) begin
            if (pending_q != PW'(MAX_PENDING)) pending_d = pending_q + 1'b1;
        end else if (fire && !bomb_pick) begin
            pending_d = pending_q - 1'b1;
        end

        inc_d      = fire;
        inc_hist_d = inc_q;
        if (pif.score_reset) begin
            pending_d  = '0;
            inc_d      = 1'b0;
            inc_hist_d = 1'b0;
        end
    end

    // Permanent range and registered blast range (follows state one cycle late).
    always_comb begin
        base_d = base_q;
        if (range_pick && (base_q != 3'(MAX_BASE_RANGE))) base_d = base_q + 3'd1;

        blast_sum = {1'b0, base_q} + ((state_q == ST_BOOSTED) ? 4'd2 : 4'd0);
        blast_d   = (blast_sum > 4'd7) ? 3'd7 : blast_sum[2:0];

        if (pif.score_reset) begin
            base_d  = 3'(BASE_RANGE);
            blast_d = 3'(BASE_RANGE);
        end
    end

    // Boost FSM next state and down-counting timer; a pickup reload beats a tick.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (boost_pick) begin
                    state_d = ST_BOOSTED;
                    timer_d = 4'(BOOST_SECS);
                end
            end
            ST_BOOSTED: begin
                if (boost_pick) begin
                    timer_d = 4'(BOOST_SECS);
                end else if (pif.OneSecPulse) begin
                    if (timer_q == 4'd1) begin
                        state_d = ST_IDLE;
                        timer_d = 4'd0;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = 4'd0;
            end
        endcase
        if (pif.score_reset) begin
            state_d = ST_IDLE;
            timer_d = 4'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            timer_q    <= 4'd0;
            latch_q    <= 1'b0;
            taken_q    <= 1'b0;
            kind_q     <= 2'b00;
            pending_q  <= '0;
            inc_q      <= 1'b0;
            inc_hist_q <= 1'b0;
            base_q     <= 3'(BASE_RANGE);
            blast_q    <= 3'(BASE_RANGE);
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            latch_q    <= latch_d;
            taken_q    <= taken_d;
            kind_q     <= kind_d;
            pending_q  <= pending_d;
            inc_q      <= inc_d;
            inc_hist_q <= inc_hist_d;
            base_q     <= base_d;
            blast_q    <= blast_d;
        end
    end

    assign pif.inc_bomb        = inc_q;
    assign pif.blast_num       = blast_q;
    assign pif.boost_active    = (state_q == ST_BOOSTED);
    assign pif.boost_secs_left = timer_q;
    assign pif.powerup_taken   = taken_q;
    assign pif.powerup_kind    = kind_q;
endmodule
